// File: rtl/wm8731_cfg_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: register map,
// power-up init table and the state encodings of the sequencer and I2C engine.
package wm8731_cfg_pkg;

  localparam logic [6:0] REG_LLINE_IN  = 7'h00;
  localparam logic [6:0] REG_RLINE_IN  = 7'h01;
  localparam logic [6:0] REG_LHP_OUT   = 7'h02;
  localparam logic [6:0] REG_ANA_PATH  = 7'h04;
  localparam logic [6:0] REG_DIG_PATH  = 7'h05;
  localparam logic [6:0] REG_PWR_DOWN  = 7'h06;
  localparam logic [6:0] REG_DIG_IF    = 7'h07;
  localparam logic [6:0] REG_SAMPLING  = 7'h08;
  localparam logic [6:0] REG_ACTIVE    = 7'h09;
  localparam logic [6:0] REG_RESET     = 7'h0F;

  localparam int NUM_INIT = 10;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } reg_write_t;

  // Codec is reset first and activated last; everything else is set up in between.
  localparam reg_write_t INIT_TABLE [NUM_INIT] = '{
    '{REG_RESET,    9'h000},
    '{REG_PWR_DOWN, 9'h010},
    '{REG_ANA_PATH, 9'h012},
    '{REG_DIG_PATH, 9'h000},
    '{REG_DIG_IF,   9'h042},
    '{REG_SAMPLING, 9'h000},
    '{REG_LLINE_IN, 9'h017},
    '{REG_RLINE_IN, 9'h017},
    '{REG_LHP_OUT,  9'h079},
    '{REG_ACTIVE,   9'h001}
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_LOAD,
    ST_INIT_WAIT,
    ST_READY,
    ST_UPD_WAIT,
    ST_ERR
  } top_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_BIT,
    PH_STOP
  } i2c_phase_e;

  // WM8731 packs the 9th data bit into the LSB of the address byte.
  function automatic logic [7:0] addr_byte(input reg_write_t w);
    return {w.addr, w.data[8]};
  endfunction

endpackage

// File: rtl/i2c_write_master.sv
// Three-byte I2C write engine: START, three bytes each with an ACK slot, STOP.
// Each SCL period is four divider ticks; a NACK aborts the frame with a STOP.
module i2c_write_master
  import wm8731_cfg_pkg::*;
#(
  parameter int DIV = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_low,
  output logic       busy,
  output logic       ok,
  output logic       nack
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  i2c_phase_e       phase, phase_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [1:0]       quarter, quarter_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [1:0]       byte_cnt, byte_cnt_nxt;
  logic [23:0]      shreg, shreg_nxt;
  logic             nack_seen, nack_seen_nxt;
  logic             scl_nxt, sda_low_nxt, ok_nxt, nack_nxt;
  logic             tick, ack_slot;

  assign tick     = (div_cnt == DIV_LAST);
  assign ack_slot = (bit_cnt == 4'd8);
  assign busy     = (phase != PH_IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= PH_IDLE;
      div_cnt   <= '0;
      quarter   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      nack_seen <= 1'b0;
      scl       <= 1'b1;
      sda_low   <= 1'b0;
      ok        <= 1'b0;
      nack      <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      div_cnt   <= div_cnt_nxt;
      quarter   <= quarter_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shreg     <= shreg_nxt;
      nack_seen <= nack_seen_nxt;
      scl       <= scl_nxt;
      sda_low   <= sda_low_nxt;
      ok        <= ok_nxt;
      nack      <= nack_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    phase_nxt     = phase;
    div_cnt_nxt   = div_cnt;
    quarter_nxt   = quarter;
    bit_cnt_nxt   = bit_cnt;
    byte_cnt_nxt  = byte_cnt;
    shreg_nxt     = shreg;
    nack_seen_nxt = nack_seen;
    scl_nxt       = scl;
    sda_low_nxt   = sda_low;
    ok_nxt        = 1'b0;
    nack_nxt      = 1'b0;

    if (phase == PH_IDLE) begin
      if (go) begin
        phase_nxt     = PH_START;
        div_cnt_nxt   = '0;
        quarter_nxt   = '0;
        bit_cnt_nxt   = '0;
        byte_cnt_nxt  = '0;
        shreg_nxt     = {byte0, byte1, byte2};
        nack_seen_nxt = 1'b0;
      end
    end else begin
      div_cnt_nxt = tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        quarter_nxt = quarter + 2'd1;
        unique case (phase)
          PH_START: begin
            // START: SDA falls while SCL is still high, then SCL drops.
            if (quarter == 2'd2) sda_low_nxt = 1'b1;
            if (quarter == 2'd3) begin
              scl_nxt   = 1'b0;
              phase_nxt = PH_BIT;
            end
          end
          PH_BIT: begin
            unique case (quarter)
              2'd0: sda_low_nxt = ack_slot ? 1'b0 : ~shreg[23];
              2'd1: scl_nxt = 1'b1;
              2'd2: if (ack_slot && sda_in) nack_seen_nxt = 1'b1;
              2'd3: begin
                scl_nxt = 1'b0;
                if (ack_slot) begin
                  bit_cnt_nxt = '0;
                  if (nack_seen || byte_cnt == 2'd2) phase_nxt = PH_STOP;
                  else byte_cnt_nxt = byte_cnt + 2'd1;
                end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
                  shreg_nxt   = {shreg[22:0], 1'b0};
                end
              end
              default: ;
            endcase
          end
          PH_STOP: begin
            // STOP: SDA pulled low under SCL low, released after SCL rises.
            unique case (quarter)
              2'd0: sda_low_nxt = 1'b1;
              2'd1: scl_nxt = 1'b1;
              2'd2: sda_low_nxt = 1'b0;
              2'd3: begin
                phase_nxt = PH_IDLE;
                ok_nxt    = ~nack_seen;
                nack_nxt  = nack_seen;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/wm8731_config_seq.sv
// WM8731 setup sequencer: plays the init table after start, then serves
// runtime register writes; handles NACK retries and sticky done/error status.
module wm8731_config_seq
  import wm8731_cfg_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         I2C_HZ    = 100_000,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [6:0] upd_addr,
  input  logic [8:0] upd_data,
  output logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int DIV     = CLK_HZ / (4 * I2C_HZ);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [3:0] IDX_LAST = 4'(NUM_INIT - 1);

  top_state_e         state, state_nxt;
  logic [3:0]         idx, idx_nxt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic               done_q, done_nxt;
  logic [6:0]         upd_addr_q;
  logic [8:0]         upd_data_q;
  logic               accept, go;
  reg_write_t         frame;
  logic               eng_busy, eng_ok, eng_nack, sda_low, sda_in;

  // NOTE: the init table is a constant ROM and needs no reset; the captured
  // update request is reset anyway so the frame mux never sees X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      retry_cnt  <= '0;
      done_q     <= 1'b0;
      upd_addr_q <= '0;
      upd_data_q <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      retry_cnt <= retry_nxt;
      done_q    <= done_nxt;
      if (accept) begin
        upd_addr_q <= upd_addr;
        upd_data_q <= upd_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry_cnt;
    done_nxt  = done_q;
    accept    = 1'b0;
    go        = 1'b0;
    upd_ready = 1'b0;

    unique case (state)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_nxt = ST_INIT_LOAD;
          idx_nxt   = '0;
          retry_nxt = '0;
          done_nxt  = 1'b0;
        end
      end
      ST_INIT_LOAD: begin
        if (!eng_busy) begin
          go        = 1'b1;
          state_nxt = ST_INIT_WAIT;
        end
      end
      ST_INIT_WAIT, ST_UPD_WAIT: begin
        if (eng_ok) begin
          retry_nxt = '0;
          if (state == ST_UPD_WAIT) begin
            state_nxt = ST_READY;
          end else if (idx == IDX_LAST) begin
            state_nxt = ST_READY;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = ST_INIT_LOAD;
          end
        end else if (eng_nack) begin
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = ST_ERR;
          end else begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            go        = 1'b1;
          end
        end
      end
      ST_READY: begin
        // A simultaneous start masks the handshake so init always wins.
        upd_ready = ~start;
        if (start) begin
          state_nxt = ST_INIT_LOAD;
          idx_nxt   = '0;
          retry_nxt = '0;
          done_nxt  = 1'b0;
        end else if (upd_valid) begin
          accept    = 1'b1;
          go        = 1'b1;
          retry_nxt = '0;
          state_nxt = ST_UPD_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame = INIT_TABLE[idx];
    if (state == ST_READY) begin
      frame.addr = upd_addr;
      frame.data = upd_data;
    end else if (state == ST_UPD_WAIT) begin
      frame.addr = upd_addr_q;
      frame.data = upd_data_q;
    end
  end

  i2c_write_master #(
    .DIV(DIV)
  ) u_master (
    .clk    (clk),
    .reset_n(reset_n),
    .go     (go),
    .byte0  ({DEV_ADDR, 1'b0}),
    .byte1  (addr_byte(frame)),
    .byte2  (frame.data[7:0]),
    .sda_in (sda_in),
    .scl    (i2c_sclk),
    .sda_low(sda_low),
    .busy   (eng_busy),
    .ok     (eng_ok),
    .nack   (eng_nack)
  );

  // Open-drain SDA: only ever pull low, the bus pull-up provides the 1.
  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
  assign sda_in   = i2c_sdat;

  assign busy  = (state == ST_INIT_LOAD) || (state == ST_INIT_WAIT) || (state == ST_UPD_WAIT);
  assign done  = done_q;
  assign error = (state == ST_ERR);

endmodule

// File: tb/tb_wm8731_config_seq.sv
// Directed bench for wm8731_config_seq with an I2C slave model that records
// every frame between START and STOP and can NACK selected bytes.
module tb_wm8731_config_seq;

  localparam int CLK_HZ_TB = 1_600_000;
  localparam int I2C_HZ_TB = 100_000;
  localparam int DIV_TB    = CLK_HZ_TB / (4 * I2C_HZ_TB);

  // {byte count, bytes} of each init frame, computed by hand from the register table.
  localparam logic [31:0] EXP_INIT [10] = '{
    32'h03341E00, 32'h03340C10, 32'h03340812, 32'h03340A00, 32'h03340E42,
    32'h03341000, 32'h03340017, 32'h03340217, 32'h03340479, 32'h03341201
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [6:0] upd_addr = '0;
  logic [8:0] upd_data = '0;
  logic       i2c_sclk;
  wire        sdat;
  logic       busy, done, error;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pullup (sdat);

  wm8731_config_seq #(
    .CLK_HZ   (CLK_HZ_TB),
    .I2C_HZ   (I2C_HZ_TB),
    .DEV_ADDR (7'h1A),
    .MAX_RETRY(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_addr (upd_addr),
    .upd_data (upd_data),
    .i2c_sclk (i2c_sclk),
    .i2c_sdat (sdat),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  // ---------------- I2C slave model ----------------
  logic        slave_low = 1'b0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  logic        in_frame = 1'b0;
  int          bit_cnt = 0, byte_cnt = 0, start_cnt = 0;
  logic [7:0]  shift = '0;
  logic [23:0] acc = '0;
  logic [31:0] frame_log [$];
  bit          nack_all = 1'b0;
  int          nack_frame = -100, nack_byte = -1;

  assign sdat = slave_low ? 1'b0 : 1'bz;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slave_low <= 1'b0;
      in_frame  <= 1'b0;
      bit_cnt   <= 0;
      prev_scl  <= 1'b1;
      prev_sda  <= 1'b1;
    end else begin
      prev_scl <= i2c_sclk;
      prev_sda <= sdat;
      if (i2c_sclk && prev_scl && prev_sda && !sdat) begin
        in_frame  <= 1'b1;
        bit_cnt   <= 0;
        byte_cnt  <= 0;
        acc       <= '0;
        start_cnt <= start_cnt + 1;
      end else if (i2c_sclk && prev_scl && !prev_sda && sdat) begin
        if (in_frame) frame_log.push_back({8'(byte_cnt), acc});
        in_frame <= 1'b0;
      end else if (in_frame && i2c_sclk && !prev_scl) begin
        if (bit_cnt < 8) begin
          shift   <= {shift[6:0], sdat};
          bit_cnt <= bit_cnt + 1;
        end
      end else if (in_frame && !i2c_sclk && prev_scl) begin
        if (bit_cnt == 8) begin
          acc       <= {acc[15:0], shift};
          byte_cnt  <= byte_cnt + 1;
          slave_low <= !(nack_all || ((start_cnt - 1) == nack_frame && byte_cnt == nack_byte));
          bit_cnt   <= 9;
        end else if (bit_cnt == 9) begin
          slave_low <= 1'b0;
          bit_cnt   <= 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < frame_log.size()) ? frame_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(done), 1);
  endtask

  task automatic wait_error(input int budget, input string tag);
    int n = 0;
    while (error !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(error), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int ready_seen);
    int n = 0;
    ready_seen = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1 && upd_ready !== 1'b0) ready_seen++;
    end
    check(tag, 32'(busy), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, t1, cyc, viol, ready_seen, n;
    logic p;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(i2c_sclk), 1);
    check("rst_sda", 32'(sdat), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_upd_ready", 32'(upd_ready), 0);
    @(negedge clk) reset_n = 1'b1;
    upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_upd_ready", 32'(upd_ready), 0);

    // 1: full init sequence, SCL period, frame contents
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 1);
    cyc = 0; t0 = -1; t1 = -1; p = i2c_sclk;
    while (cyc < 2000 && t1 < 0) begin
      @(negedge clk);
      cyc++;
      if (i2c_sclk && !p) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
      p = i2c_sclk;
    end
    check("t1_scl_period", 32'(t1 - t0), 32'(4 * DIV_TB));
    wait_done(10000, "t1_done");
    check("t1_busy_end", 32'(busy), 0);
    check("t1_error", 32'(error), 0);
    check("t1_upd_ready", 32'(upd_ready), 1);
    check("t1_frame_count", 32'(frame_log.size()), 10);
    for (int i = 0; i < 10; i++) check($sformatf("t1_frame%0d", i), log_at(i), EXP_INIT[i]);

    // 2: one NACK on byte1 of entry 3 -> entry 3 sent twice
    frame_log.delete();
    nack_frame = start_cnt + 3;
    nack_byte  = 1;
    pulse_start();
    check("t2_done_cleared", 32'(done), 0);
    wait_done(12000, "t2_done");
    nack_frame = -100;
    check("t2_error", 32'(error), 0);
    check("t2_frame_count", 32'(frame_log.size()), 11);
    check("t2_nacked_frame", log_at(3), 32'h0200340A);
    check("t2_retry_frame", log_at(4), EXP_INIT[3]);
    check("t2_last_frame", log_at(10), EXP_INIT[9]);

    // 3: NACK everything -> 4 attempts of entry 0, then ERR
    frame_log.delete();
    nack_all = 1'b1;
    pulse_start();
    wait_error(6000, "t3_error");
    check("t3_busy", 32'(busy), 0);
    check("t3_done", 32'(done), 0);
    check("t3_upd_ready", 32'(upd_ready), 0);
    repeat (1000) @(negedge clk);
    check("t3_attempts", 32'(frame_log.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_attempt%0d", i), log_at(i), 32'h01000034);
    nack_all = 1'b0;

    // 4: runtime update after done
    pulse_start();
    check("t4_error_cleared", 32'(error), 0);
    wait_done(10000, "t4_init_done");
    frame_log.delete();
    @(negedge clk);
    upd_addr  = 7'h02;
    upd_data  = 9'h07F;
    upd_valid = 1'b1;
    #1 check("t4_ready_before", 32'(upd_ready), 1);
    @(negedge clk) upd_valid = 1'b0;
    check("t4_ready_after_accept", 32'(upd_ready), 0);
    check("t4_busy_after_accept", 32'(busy), 1);
    wait_idle(2000, "t4_idle", ready_seen);
    check("t4_ready_low_in_frame", 32'(ready_seen), 0);
    check("t4_ready_back", 32'(upd_ready), 1);
    check("t4_done_kept", 32'(done), 1);
    check("t4_frame", log_at(0), 32'h0334047F);

    // 5: start and upd_valid together in READY; valid held through init
    frame_log.delete();
    @(negedge clk);
    start     = 1'b1;
    upd_valid = 1'b1;
    upd_addr  = 7'h05;
    upd_data  = 9'h0AB;
    #1 check("t5_start_wins", 32'(upd_ready), 0);
    @(negedge clk) start = 1'b0;
    check("t5_busy", 32'(busy), 1);
    viol = 0; n = 0;
    while (done !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
      if (upd_ready === 1'b1 && done !== 1'b1) viol++;
    end
    check("t5_done", 32'(done), 1);
    check("t5_no_early_accept", 32'(viol), 0);
    check("t5_ready_in_ready", 32'(upd_ready), 1);
    @(negedge clk) upd_valid = 1'b0;
    check("t5_busy_upd", 32'(busy), 1);
    wait_idle(2000, "t5_idle", ready_seen);
    check("t5_frame_count", 32'(frame_log.size()), 11);
    check("t5_first_frame", log_at(0), EXP_INIT[0]);
    check("t5_upd_frame", log_at(10), 32'h03340AAB);

    // 6: reset in the middle of a byte
    pulse_start();
    n = 0;
    while (!(bit_cnt == 1 && i2c_sclk === 1'b0 && sdat === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_mid_byte", 32'(sdat), 0);
    #1 reset_n = 1'b0;
    #1;
    check("t6_sclk_released", 32'(i2c_sclk), 1);
    check("t6_sda_released", 32'(sdat), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    check("t6_upd_ready", 32'(upd_ready), 0);
    frame_log.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    n = 0;
    while (frame_log.size() == 0 && n < 2000) begin @(negedge clk); n++; end
    check("t6_restart_frame", log_at(0), EXP_INIT[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
